// File: rtl/md_pkg.sv
// md_pkg: shared multiply/divide op codes, FSM states and default latencies
package md_pkg;
   localparam logic [2:0] MDOP_NONE  = 3'd0;
   localparam logic [2:0] MDOP_MULT  = 3'd1;
   localparam logic [2:0] MDOP_MULTU = 3'd2;
   localparam logic [2:0] MDOP_DIV   = 3'd3;
   localparam logic [2:0] MDOP_DIVU  = 3'd4;
   localparam logic [2:0] MDOP_MTHI  = 3'd5;
   localparam logic [2:0] MDOP_MTLO  = 3'd6;
   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
   localparam int CNT_W_DEF    = 4;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational HI/LO result for mult/multu/div/divu, holding HI/LO on divide by zero
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  mdop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] cur_hi,
   input  logic [31:0] cur_lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);
   logic [63:0] sprod, uprod;
   logic [31:0] sdiv, udiv, squo, srem, uquo, urem;
   logic        dz, ovf;
   always_comb begin
      sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      uprod = {32'b0, a} * {32'b0, b};
      dz    = (b == '0);
      ovf   = (a == 32'h8000_0000) && (b == '1);
      // dividing the overflow case by +1 yields the required 0x80000000 remainder 0
      sdiv  = (dz || ovf) ? 32'd1 : b;
      udiv  = dz ? 32'd1 : b;
      squo  = $signed(a) / $signed(sdiv);
      srem  = $signed(a) % $signed(sdiv);
      uquo  = a / udiv;
      urem  = a % udiv;
      res_hi = cur_hi;
      res_lo = cur_lo;
      case (mdop)
         MDOP_MULT:  {res_hi, res_lo} = sprod;
         MDOP_MULTU: {res_hi, res_lo} = uprod;
         MDOP_DIV:   {res_hi, res_lo} = dz ? {cur_hi, cur_lo} : {srem, squo};
         MDOP_DIVU:  {res_hi, res_lo} = dz ? {cur_hi, cur_lo} : {urem, uquo};
         default:    {res_hi, res_lo} = {cur_hi, cur_lo};
      endcase
   end
endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div sequencer owning HI/LO, with D/F stall request
module md_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  mdop,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rsel,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);
   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [31:0]        pend_hi, pend_lo, res_hi, res_lo;
   logic               long_op, is_mul;
   assign long_op   = start && (mdop >= MDOP_MULT) && (mdop <= MDOP_DIVU);
   assign is_mul    = (mdop == MDOP_MULT) || (mdop == MDOP_MULTU);
   assign stall_req = d_is_md && (busy || long_op);
   assign md_out    = rsel ? lo : hi;
   md_arith u_arith (
      .mdop   (mdop),
      .a      (a),
      .b      (b),
      .cur_hi (hi),
      .cur_lo (lo),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else if (state == IDLE) begin
         if (long_op) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            count   <= is_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
            state   <= RUN;
            busy    <= 1'b1;
         end else if (start && mdop == MDOP_MTHI) begin
            hi <= a;
         end else if (start && mdop == MDOP_MTLO) begin
            lo <= a;
         end
      end else if (count == CNT_W'(1)) begin
         hi    <= pend_hi;
         lo    <= pend_lo;
         count <= '0;
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         count <= count - 1'b1;
      end
   end
   a_no_issue_in_run: assert property (@(posedge clk) disable iff (!rst_n)
      !(state == RUN && start && mdop >= MDOP_MULT && mdop <= MDOP_MTLO))
      else $warning("md_ctrl: md op issued while busy, ignored");
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed vectors for md_ctrl latency, arithmetic, stall and reset behaviour
module tb_md_ctrl;
   import md_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mdop = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        rsel = 1'b0;
   logic        d_is_md = 1'b0;
   logic        busy, stall_req;
   logic [31:0] hi, lo, md_out;
   int          checks = 0;
   int          errors = 0;
   int          nb, ns;
   md_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mdop      (mdop),
      .a         (a),
      .b         (b),
      .rsel      (rsel),
      .d_is_md   (d_is_md),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo),
      .md_out    (md_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // issue a long op, then count busy cycles and stall cycles (start cycle, busy cycles, first idle cycle)
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic d, output int nbusy, output int nstall);
      nbusy = 0;
      nstall = 0;
      @(negedge clk);
      start = 1'b1; mdop = op; a = x; b = y; d_is_md = d;
      #1 nstall += int'(stall_req);
      @(posedge clk);
      #1 start = 1'b0; mdop = MDOP_NONE;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         nstall += int'(stall_req);
         if (!busy) break;
         nbusy++;
      end
      d_is_md = 1'b0;
   endtask
   task automatic move_to(input logic [2:0] op, input logic [31:0] x);
      @(negedge clk);
      start = 1'b1; mdop = op; a = x; d_is_md = 1'b1;
      #1 check("mt_stall", {31'b0, stall_req}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0; mdop = MDOP_NONE; d_is_md = 1'b0;
      @(negedge clk);
      check("mt_busy", {31'b0, busy}, 32'd0);
   endtask
   initial begin
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, nb, ns);
      check("mult_busy", nb, 5);
      check("mult_stall", ns, 6);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFA);
      check("mdout_hi", md_out, 32'hFFFF_FFFF);
      run_op(MDOP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, ns);
      check("multu_busy", nb, 5);
      check("multu_stall", ns, 0);
      check("multu_hi", hi, 32'h0000_0002);
      check("multu_lo", lo, 32'hFFFF_FFFA);
      run_op(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
      check("div_busy", nb, 10);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      run_op(MDOP_DIVU, 32'd7, 32'd2, 1'b0, nb, ns);
      check("divu_lo", lo, 32'd3);
      check("divu_hi", hi, 32'd1);
      move_to(MDOP_MTHI, 32'h11);
      check("mthi_hi", hi, 32'h11);
      move_to(MDOP_MTLO, 32'h22);
      check("mtlo_lo", lo, 32'h22);
      rsel = 1'b1;
      #1 check("mdout_lo", md_out, 32'h22);
      run_op(MDOP_DIV, 32'd5, 32'd0, 1'b0, nb, ns);
      check("dz_busy", nb, 10);
      check("dz_hi", hi, 32'h11);
      check("dz_lo", lo, 32'h22);
      run_op(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);
      // asynchronous reset during the third busy cycle of a divide
      @(negedge clk);
      start = 1'b1; mdop = MDOP_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1 start = 1'b0; mdop = MDOP_NONE;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(MDOP_DIVU, 32'd100, 32'd7, 1'b0, nb, ns);
      check("post_rst_busy", nb, 10);
      check("post_rst_lo", lo, 32'd14);
      check("post_rst_hi", hi, 32'd2);
      // mtlo issued during RUN is dropped; the pending product still commits
      @(negedge clk);
      start = 1'b1; mdop = MDOP_MULT; a = 32'd3; b = 32'd4;
      @(posedge clk);
      #1 start = 1'b0; mdop = MDOP_NONE;
      nb = 1;
      @(negedge clk);
      start = 1'b1; mdop = MDOP_MTLO; a = 32'h55;
      @(posedge clk);
      #1 start = 1'b0; mdop = MDOP_NONE;
      @(negedge clk);
      check("run_mtlo_lo", lo, 32'd14);
      check("run_mdout", md_out, 32'd14);
      nb++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) break;
         nb++;
      end
      check("run_mtlo_busy", nb, 5);
      check("run_mtlo_hi", hi, 32'd0);
      check("run_mtlo_res", lo, 32'd12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
